// File: rtl/traffic_pkg.sv
// Shared light codes and error-bit indices for the intersection controller and its lamp monitor.
package traffic_pkg;

    typedef enum logic [1:0] {
        LIGHT_R   = 2'd0,
        LIGHT_Y   = 2'd1,
        LIGHT_G   = 2'd2,
        LIGHT_BAD = 2'd3
    } light_e;

    localparam int unsigned ERR_ILLEGAL     = 0;
    localparam int unsigned ERR_CONFLICT    = 1;
    localparam int unsigned ERR_BAD_SEQ     = 2;
    localparam int unsigned ERR_SHORT_GREEN = 3;
    localparam int unsigned ERR_BAD_YELLOW  = 4;
    localparam int unsigned ERR_W           = 5;

    // Exactly one lamp lit gives its code; dark or multiple lamps are BAD.
    function automatic light_e decode_lamps(input logic r, input logic y, input logic g);
        light_e code;
        unique case ({r, y, g})
            3'b100:  code = LIGHT_R;
            3'b010:  code = LIGHT_Y;
            3'b001:  code = LIGHT_G;
            default: code = LIGHT_BAD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/lamp_phase_tracker.sv
// Per-direction lamp decode, saturating phase-duration counter and sequencing checks.
module lamp_phase_tracker
    import traffic_pkg::*;
#(
    parameter int unsigned GRN_MIN = 6,
    parameter int unsigned YEL_CYC = 1,
    parameter int unsigned DUR_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r_i,
    input  logic             y_i,
    input  logic             g_i,
    input  logic             primed_i,
    output logic [1:0]       light_next_o,
    output logic [1:0]       light_o,
    output logic [DUR_W-1:0] dur_o,
    output logic [ERR_W-1:0] err_o
);

    light_e           light_q, light_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             changed;
    logic             legal_step;

    always_comb begin
        light_d    = decode_lamps(r_i, y_i, g_i);
        changed    = (light_d != light_q);
        dur_d      = dur_q;
        legal_step = 1'b0;
        err_o      = '0;

        if (changed) begin
            dur_d = DUR_W'(1);
        end else if (dur_q != {DUR_W{1'b1}}) begin
            dur_d = dur_q + DUR_W'(1);
        end

        legal_step = (light_q == LIGHT_G && light_d == LIGHT_Y) ||
                     (light_q == LIGHT_Y && light_d == LIGHT_R) ||
                     (light_q == LIGHT_R && light_d == LIGHT_G);

        err_o[ERR_ILLEGAL] = (light_d == LIGHT_BAD);

        if (primed_i) begin
            err_o[ERR_BAD_SEQ]     = changed && !legal_step;
            err_o[ERR_SHORT_GREEN] = (light_q == LIGHT_G) && (light_d == LIGHT_Y) &&
                                     (dur_q < DUR_W'(GRN_MIN));
            // A held yellow flags only on the sample that would push it to YEL_CYC+1.
            if (light_q == LIGHT_Y) begin
                err_o[ERR_BAD_YELLOW] = changed ? (dur_q != DUR_W'(YEL_CYC))
                                                : (dur_q == DUR_W'(YEL_CYC));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            light_q <= LIGHT_BAD;
            dur_q   <= '0;
        end else begin
            light_q <= light_d;
            dur_q   <= dur_d;
        end
    end

    assign light_next_o = light_d;
    assign light_o      = light_q;
    assign dur_o        = dur_q;

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Lamp-side protocol monitor: two phase trackers plus conflict check and violation accounting.
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned GRN_MIN_A = 6,
    parameter int unsigned GRN_MIN_B = 5,
    parameter int unsigned YEL_CYC   = 1,
    parameter int unsigned DUR_W     = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Ra,
    input  logic             Ya,
    input  logic             Ga,
    input  logic             Rb,
    input  logic             Yb,
    input  logic             Gb,
    input  logic             clr,
    output logic [1:0]       light_a,
    output logic [1:0]       light_b,
    output logic [DUR_W-1:0] dur_a,
    output logic [DUR_W-1:0] dur_b,
    output logic [ERR_W-1:0] err_now,
    output logic [ERR_W-1:0] err_sticky,
    output logic [CNT_W-1:0] viol_count,
    output logic             err_irq
);

    logic [1:0]       next_a, next_b;
    logic [ERR_W-1:0] err_a, err_b;
    logic             primed_q, primed_d;
    logic [ERR_W-1:0] err_now_q, err_now_d;
    logic [ERR_W-1:0] err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] viol_count_q, viol_count_d;
    logic             err_irq_q, err_irq_d;
    logic             conflict;

    lamp_phase_tracker #(
        .GRN_MIN (GRN_MIN_A),
        .YEL_CYC (YEL_CYC),
        .DUR_W   (DUR_W)
    ) u_track_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .r_i          (Ra),
        .y_i          (Ya),
        .g_i          (Ga),
        .primed_i     (primed_q),
        .light_next_o (next_a),
        .light_o      (light_a),
        .dur_o        (dur_a),
        .err_o        (err_a)
    );

    lamp_phase_tracker #(
        .GRN_MIN (GRN_MIN_B),
        .YEL_CYC (YEL_CYC),
        .DUR_W   (DUR_W)
    ) u_track_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .r_i          (Rb),
        .y_i          (Yb),
        .g_i          (Gb),
        .primed_i     (primed_q),
        .light_next_o (next_b),
        .light_o      (light_b),
        .dur_o        (dur_b),
        .err_o        (err_b)
    );

    always_comb begin
        conflict     = (next_a == LIGHT_Y || next_a == LIGHT_G) &&
                       (next_b == LIGHT_Y || next_b == LIGHT_G);
        err_now_d    = err_a | err_b;
        err_now_d[ERR_CONFLICT] = conflict;
        primed_d     = 1'b1;
        // clr drops the old history but keeps whatever this sample found.
        err_sticky_d = (clr ? '0 : err_sticky_q) | err_now_d;
        viol_count_d = clr ? '0 : viol_count_q;
        if (|err_now_d && viol_count_d != {CNT_W{1'b1}}) begin
            viol_count_d = viol_count_d + CNT_W'(1);
        end
        err_irq_d    = |err_sticky_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            primed_q     <= 1'b0;
            err_now_q    <= '0;
            err_sticky_q <= '0;
            viol_count_q <= '0;
            err_irq_q    <= 1'b0;
        end else begin
            primed_q     <= primed_d;
            err_now_q    <= err_now_d;
            err_sticky_q <= err_sticky_d;
            viol_count_q <= viol_count_d;
            err_irq_q    <= err_irq_d;
        end
    end

    assign err_now    = err_now_q;
    assign err_sticky = err_sticky_q;
    assign viol_count = viol_count_q;
    assign err_irq    = err_irq_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Self-checking bench: directed protocol scenarios plus randomized lamp traffic against a model.
module tb_traffic_lamp_monitor;

    localparam int GMA = 6;
    localparam int GMB = 5;
    localparam int YC  = 1;
    localparam int DMAX = 255;
    localparam int CMAX = 65535;

    localparam logic [2:0] LR   = 3'b100;
    localparam logic [2:0] LY   = 3'b010;
    localparam logic [2:0] LG   = 3'b001;
    localparam logic [2:0] LOFF = 3'b000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Ra = 1'b0, Ya = 1'b0, Ga = 1'b0;
    logic        Rb = 1'b0, Yb = 1'b0, Gb = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  light_a, light_b;
    logic [7:0]  dur_a, dur_b;
    logic [4:0]  err_now, err_sticky;
    logic [15:0] viol_count;
    logic        err_irq;

    int checks = 0;
    int failures = 0;

    // Reference state, held as plain integers.
    int m_la, m_lb, m_da, m_db, m_now, m_sticky, m_cnt;
    bit m_primed;

    traffic_lamp_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Ra         (Ra),
        .Ya         (Ya),
        .Ga         (Ga),
        .Rb         (Rb),
        .Yb         (Yb),
        .Gb         (Gb),
        .clr        (clr),
        .light_a    (light_a),
        .light_b    (light_b),
        .dur_a      (dur_a),
        .dur_b      (dur_b),
        .err_now    (err_now),
        .err_sticky (err_sticky),
        .viol_count (viol_count),
        .err_irq    (err_irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [2:0] l);
        if (l == LR) return 0;
        if (l == LY) return 1;
        if (l == LG) return 2;
        return 3;
    endfunction

    function automatic int dir_err(input int o, input int n, input int d, input bit p,
                                   input int gmin);
        int e = 0;
        if (n == 3) e |= 1;
        if (p) begin
            if (n != o && !((o == 2 && n == 1) || (o == 1 && n == 0) || (o == 0 && n == 2)))
                e |= 4;
            if (o == 2 && n == 1 && d < gmin) e |= 8;
            if (o == 1 && n != 1 && d != YC) e |= 16;
            if (o == 1 && n == 1 && d + 1 == YC + 1) e |= 16;
        end
        return e;
    endfunction

    function automatic int next_dur(input int o, input int n, input int d);
        if (n != o) return 1;
        return (d >= DMAX) ? DMAX : d + 1;
    endfunction

    task automatic model_step(input logic [2:0] la, input logic [2:0] lb, input logic c,
                              input logic rn);
        int na, nb, e;
        if (!rn) begin
            m_la = 3; m_lb = 3; m_da = 0; m_db = 0;
            m_now = 0; m_sticky = 0; m_cnt = 0; m_primed = 0;
        end else begin
            na = decode(la);
            nb = decode(lb);
            e  = dir_err(m_la, na, m_da, m_primed, GMA) | dir_err(m_lb, nb, m_db, m_primed, GMB);
            if ((na == 1 || na == 2) && (nb == 1 || nb == 2)) e |= 2;
            m_da = next_dur(m_la, na, m_da);
            m_db = next_dur(m_lb, nb, m_db);
            m_la = na;
            m_lb = nb;
            m_primed = 1;
            m_now = e;
            m_sticky = (c ? 0 : m_sticky) | e;
            m_cnt = c ? 0 : m_cnt;
            if (e != 0 && m_cnt < CMAX) m_cnt++;
        end
    endtask

    task automatic compare_all();
        check_val("light_a", 32'(light_a), 32'(m_la));
        check_val("light_b", 32'(light_b), 32'(m_lb));
        check_val("dur_a", 32'(dur_a), 32'(m_da));
        check_val("dur_b", 32'(dur_b), 32'(m_db));
        check_val("err_now", 32'(err_now), 32'(m_now));
        check_val("err_sticky", 32'(err_sticky), 32'(m_sticky));
        check_val("viol_count", 32'(viol_count), 32'(m_cnt));
        check_val("err_irq", 32'(err_irq), 32'(m_sticky != 0));
    endtask

    task automatic cyc(input logic [2:0] la, input logic [2:0] lb, input logic c, input logic rn);
        {Ra, Ya, Ga} = la;
        {Rb, Yb, Gb} = lb;
        clr   = c;
        rst_n = rn;
        @(posedge clk);
        model_step(la, lb, c, rn);
        #1;
        compare_all();
    endtask

    function automatic logic [2:0] legal_a(input int t);
        return (t < 6) ? LG : (t == 6) ? LY : LR;
    endfunction

    function automatic logic [2:0] legal_b(input int t);
        return (t < 7) ? LR : (t < 12) ? LG : LY;
    endfunction

    task automatic do_reset();
        cyc(LOFF, LOFF, 1'b0, 1'b0);
        cyc(LR, LG, 1'b0, 1'b0);
    endtask

    initial begin
        int t;
        logic [2:0] ra, rb;

        do_reset();
        check_val("reset_light_a", 32'(light_a), 3);
        check_val("reset_viol", 32'(viol_count), 0);

        // Legal controller sequence for three full cycles.
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < 13; s++) begin
                cyc(legal_a(s), legal_b(s), 1'b0, 1'b1);
                if (s == 5) check_val("dur_a_pre_yellow", 32'(dur_a), 6);
            end
        end
        check_val("legal_sticky", 32'(err_sticky), 0);
        check_val("legal_count", 32'(viol_count), 0);

        // Both greens together.
        do_reset();
        cyc(LG, LG, 1'b0, 1'b1);
        check_val("conflict_now", 32'(err_now), 32'h02);
        check_val("conflict_count", 32'(viol_count), 1);
        check_val("conflict_irq", 32'(err_irq), 1);

        // Short green then long yellow.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(LG, LR, 1'b0, 1'b1);
        cyc(LY, LR, 1'b0, 1'b1);
        check_val("short_green_now", 32'(err_now), 32'h08);
        check_val("short_green_sticky", 32'(err_sticky), 32'h08);
        cyc(LY, LR, 1'b0, 1'b1);
        check_val("long_yellow_pulse", 32'(err_now), 32'h10);
        cyc(LY, LR, 1'b0, 1'b1);
        check_val("long_yellow_once", 32'(err_now), 0);
        cyc(LR, LR, 1'b0, 1'b1);

        // Bad sequence and illegal patterns.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(LG, LR, 1'b0, 1'b1);
        cyc(LR, LR, 1'b0, 1'b1);
        check_val("g_to_r_now", 32'(err_now), 32'h04);
        cyc(3'b101, LR, 1'b0, 1'b1);
        check_val("double_lamp_light", 32'(light_a), 3);
        check_val("double_lamp_now", 32'(err_now), 32'h05);
        cyc(LOFF, LR, 1'b0, 1'b1);
        check_val("dark_light", 32'(light_a), 3);
        check_val("dark_now", 32'(err_now), 32'h01);

        // clr colliding with a fresh violation, then clr alone.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(LG, LG, 1'b0, 1'b1);
        cyc(LY, LY, 1'b0, 1'b1);
        cyc(LR, LR, 1'b0, 1'b1);
        check_val("pre_clr_count", 32'(viol_count), 5);
        cyc(LG, LG, 1'b1, 1'b1);
        check_val("clr_collide_count", 32'(viol_count), 1);
        check_val("clr_collide_sticky", 32'(err_sticky), 32'h02);
        cyc(LY, LY, 1'b0, 1'b1);
        cyc(LR, LR, 1'b1, 1'b1);
        check_val("clr_alone_count", 32'(viol_count), 0);
        check_val("clr_alone_irq", 32'(err_irq), 0);

        // Reset during A yellow, released into A red.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(LG, LR, 1'b0, 1'b1);
        cyc(LY, LR, 1'b0, 1'b1);
        cyc(LY, LR, 1'b0, 1'b0);
        check_val("mid_reset_dur_a", 32'(dur_a), 0);
        check_val("mid_reset_light_a", 32'(light_a), 3);
        cyc(LR, LG, 1'b0, 1'b1);
        check_val("rearm_dur_a", 32'(dur_a), 1);
        check_val("rearm_now", 32'(err_now), 0);

        // Duration saturation on a long all-red hold.
        do_reset();
        for (int i = 0; i < 300; i++) cyc(LR, LR, 1'b0, 1'b1);
        check_val("dur_a_saturated", 32'(dur_a), 255);
        check_val("dur_b_saturated", 32'(dur_b), 255);

        // Mostly legal traffic with random glitches, clears and resets.
        do_reset();
        t = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                ra = legal_a(t);
                rb = legal_b(t);
            end else begin
                ra = 3'($urandom_range(0, 7));
                rb = 3'($urandom_range(0, 7));
            end
            cyc(ra, rb, logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 63) != 0));
            t = (t + 1) % 13;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
